// File: rtl/svc_soc_uart_tx_buf.sv
// Memory-mapped, FIFO-buffered 8N1 UART transmitter on the SoC I/O bus.
// Optional 16-bit drop counter at offset 0x8 is enabled by defining SVC_UART_TX_OVFCNT_EN.
module svc_soc_uart_tx_buf #(
    parameter int unsigned CLOCK_FREQ = 25_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    output logic        uart_tx
);

    localparam int unsigned DIV = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic [31:0]   r_rdata;

    state_t        r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [2:0]    r_bit, w_bit_d;
    logic [7:0]    r_shift, w_shift_d;
    logic          r_tx, w_tx_d;

    logic w_whit, w_rhit, w_full, w_empty, w_busy;
    logic w_push_req, w_push, w_drop, w_pop, w_clr;
    logic [7:0]  w_level8;
    logic [31:0] w_status, w_rdata_d;
    logic w_unused_ok;

    assign w_whit   = io_wen && (io_waddr[31:4] == BASE_ADDR[31:4]);
    assign w_rhit   = io_ren && (io_raddr[31:4] == BASE_ADDR[31:4]);
    assign w_full   = (r_level == LVL_FULL);
    assign w_empty  = (r_level == '0);
    assign w_busy   = (r_state != StIdle);
    assign w_level8 = 8'(r_level);

    // Full is judged on the registered level, so a same-cycle pop cannot rescue a push.
    assign w_push_req = w_whit && (io_waddr[3:0] == 4'h0) && io_wstrb[0];
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_clr      = w_whit && (io_waddr[3:0] == 4'h4) && io_wstrb[0] && io_wdata[3];

    assign w_status    = {16'h0, w_level8, 4'h0, r_ovf, w_busy, w_empty, w_full};
    assign w_unused_ok = ^{io_wdata[31:8], io_wstrb[3:1]};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= io_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop)     r_ovf <= 1'b1;
            else if (w_clr) r_ovf <= 1'b0;
        end
    end

`ifdef SVC_UART_TX_OVFCNT_EN
    logic [15:0] r_ovfcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovfcnt <= '0;
        end else if (w_clr) begin
            r_ovfcnt <= '0;
        end else if (w_drop && (r_ovfcnt != 16'hFFFF)) begin
            r_ovfcnt <= r_ovfcnt + 16'd1;
        end
    end
`endif

    always_comb begin
        w_rdata_d = '0;
        if (w_rhit) begin
            case (io_raddr[3:0])
                4'h4:    w_rdata_d = w_status;
`ifdef SVC_UART_TX_OVFCNT_EN
                4'h8:    w_rdata_d = {16'h0, r_ovfcnt};
`endif
                default: w_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else     r_rdata <= w_rdata_d;
    end

    // Line level is computed alongside the next state so uart_tx comes straight from a flop.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_tx_d    = r_tx;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                w_tx_d  = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = r_mem[r_rptr];
                    w_state_d = StStart;
                    w_tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_state_d = StData;
                    w_tx_d    = r_shift[0];
                end
            end
            StData: begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_d = '0;
                    if (r_bit == 3'd7) begin
                        w_state_d = StStop;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_shift_d = {1'b0, r_shift[7:1]};
                        w_tx_d    = r_shift[1];
                    end
                end
            end
            StStop: begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                    w_tx_d    = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_tx    <= w_tx_d;
        end
    end

    assign io_rdata = r_rdata;
    assign uart_tx  = r_tx;

endmodule

// File: tb/tb_svc_soc_uart_tx_buf.sv
// Directed self-checking bench for svc_soc_uart_tx_buf (DIV=10, DEPTH=4).
module tb_svc_soc_uart_tx_buf;

    localparam logic [31:0] BASE = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_wen = 1'b0;
    logic [31:0] io_waddr = '0;
    logic [31:0] io_wdata = '0;
    logic [3:0]  io_wstrb = '0;
    logic        io_ren = 1'b0;
    logic [31:0] io_raddr = '0;
    logic [31:0] io_rdata;
    logic        uart_tx;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    svc_soc_uart_tx_buf #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .DEPTH     (4),
        .BASE_ADDR (BASE)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .io_wen  (io_wen),
        .io_waddr(io_waddr),
        .io_wdata(io_wdata),
        .io_wstrb(io_wstrb),
        .io_ren  (io_ren),
        .io_raddr(io_raddr),
        .io_rdata(io_rdata),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decodes frames at bit centres and counts low cycles.
    bit         in_frame = 1'b0;
    int         pos = 0;
    logic       prev_tx = 1'b1;
    logic [7:0] rx_sh = '0;
    bit         rx_ok = 1'b1;
    int         rx_t0 = 0;
    int         low_cnt = 0;
    logic [7:0] rx_bytes[$];
    int         rx_start[$];
    bit         rx_oks[$];

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            prev_tx  = 1'b1;
        end else begin
            if (uart_tx === 1'b0) low_cnt++;
            if (!in_frame) begin
                if (prev_tx === 1'b1 && uart_tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    rx_t0    = cyc;
                    rx_ok    = 1'b1;
                    rx_sh    = '0;
                end
            end else begin
                pos++;
                if (pos == 5 && uart_tx !== 1'b0) rx_ok = 1'b0;
                if (pos >= 15 && pos <= 85 && (pos - 15) % 10 == 0)
                    rx_sh[(pos - 15) / 10] = uart_tx;
                if (pos == 95) begin
                    if (uart_tx !== 1'b1) rx_ok = 1'b0;
                    rx_bytes.push_back(rx_sh);
                    rx_start.push_back(rx_t0);
                    rx_oks.push_back(rx_ok);
                    in_frame = 1'b0;
                end
            end
            prev_tx = uart_tx;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        io_wen   = 1'b1;
        io_waddr = a;
        io_wdata = d;
        io_wstrb = s;
        @(negedge clk);
        io_wen   = 1'b0;
        io_wstrb = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        io_ren   = 1'b1;
        io_raddr = a;
        @(negedge clk);
        d      = io_rdata;
        io_ren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        exp_tx;
        logic [7:0]  t3 [6];
        t3 = '{8'hA1, 8'h02, 8'h33, 8'hC4, 8'h85, 8'hFF};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_rdata", io_rdata, 32'h0);
        rst = 1'b0;
        bus_read(BASE + 32'h4, d);
        check("rst_status", d, 32'h0000_0002);
        @(negedge clk);
        check("rdata_idle", io_rdata, 32'h0);

        // Single byte 0x55, cycle-accurate line check
        bus_write(BASE, 32'h55, 4'h1);
        for (int k = 1; k <= 103; k++) begin
            if (k < 2)        exp_tx = 1'b1;
            else if (k <= 11) exp_tx = 1'b0;
            else if (k <= 91) exp_tx = (8'h55 >> ((k - 12) / 10)) & 1'b1;
            else              exp_tx = 1'b1;
            check($sformatf("t2_tx_c%0d", k), {31'h0, uart_tx}, {31'h0, exp_tx});
            if (k == 102) check("t2_busy", io_rdata, 32'h0000_0006);
            if (k == 103) begin
                check("t2_idle", io_rdata, 32'h0000_0002);
                io_ren = 1'b0;
            end
            if (k == 101) begin
                io_ren   = 1'b1;
                io_raddr = BASE + 32'h4;
            end
            if (k < 103) @(negedge clk);
        end

        // Six back-to-back writes: one popped, four queued, sixth dropped
        rx_bytes.delete();
        rx_start.delete();
        rx_oks.delete();
        for (int i = 0; i < 6; i++) bus_write(BASE, {24'h0, t3[i]}, 4'h1);
        bus_read(BASE + 32'h4, d);
        check("t3_status", d, 32'h0000_040D);
        bus_read(BASE + 32'h8, d);
`ifdef SVC_UART_TX_OVFCNT_EN
        check("t3_ovfcnt", d, 32'h1);
`else
        check("t3_ovfcnt_off", d, 32'h0);
`endif
        for (int i = 0; i < 800 && rx_bytes.size() < 5; i++) @(negedge clk);
        repeat (120) @(negedge clk);
        check("t3_nframes", rx_bytes.size(), 32'd5);
        for (int i = 0; i < 5 && i < rx_bytes.size(); i++) begin
            check($sformatf("t3_byte%0d", i), {24'h0, rx_bytes[i]}, {24'h0, t3[i]});
            check($sformatf("t3_framing%0d", i), {31'h0, rx_oks[i]}, 32'h1);
            if (i > 0)
                check($sformatf("t3_gap%0d", i), rx_start[i] - rx_start[i-1], 32'd101);
        end
        bus_read(BASE + 32'h4, d);
        check("t3_drained", d, 32'h0000_000A);

        // Clear ovf
        bus_write(BASE + 32'h4, 32'h8, 4'h1);
        bus_read(BASE + 32'h4, d);
        check("t4_status", d, 32'h0000_0002);
`ifdef SVC_UART_TX_OVFCNT_EN
        bus_read(BASE + 32'h8, d);
        check("t4_ovfcnt", d, 32'h0);
`endif

        // Reset in the middle of DATA (bit 4 of 0x0F is low)
        bus_write(BASE, 32'h0F, 4'h1);
        bus_write(BASE, 32'hF0, 4'h1);
        repeat (53) @(negedge clk);
        check("t5_pre_tx", {31'h0, uart_tx}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_tx", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        rx_bytes.delete();
        low_cnt = 0;
        bus_read(BASE + 32'h4, d);
        check("t5_status", d, 32'h0000_0002);
        repeat (200) @(negedge clk);
        check("t5_no_edges", low_cnt, 32'd0);
        check("t5_no_frames", rx_bytes.size(), 32'd0);

        // STATUS read alongside a wstrb=0 TXDATA write; decode corners
        io_wen   = 1'b1;
        io_waddr = BASE;
        io_wdata = 32'h77;
        io_wstrb = 4'h0;
        io_ren   = 1'b1;
        io_raddr = BASE + 32'h4;
        @(negedge clk);
        io_wen = 1'b0;
        io_ren = 1'b0;
        check("t6_same_cycle", io_rdata, 32'h0000_0002);
        bus_read(BASE + 32'h4, d);
        check("t6_level", d, 32'h0000_0002);
        bus_write(BASE + 32'h10, 32'h33, 4'h1);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'h4, d);
        check("t6_nohit_push", d, 32'h0000_0002);
        bus_read(BASE + 32'hC, d);
        check("t6_reserved", d, 32'h0);
        bus_read(BASE, d);
        check("t6_txdata_rd", d, 32'h0);
        bus_read(BASE + 32'h14, d);
        check("t6_nohit_rd", d, 32'h0);
        low_cnt = 0;
        repeat (30) @(negedge clk);
        check("t6_line_idle", low_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
